// File: rtl/blake2b_mblock_loader_if.sv
// Word-stream channel feeding the BLAKE2b message-block loader.
interface blake2b_mblock_loader_if #(
    parameter int unsigned WORD_W = 64
);
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;
    logic              s_last;
    logic [3:0]        s_nbytes;

    modport master (output s_valid, s_data, s_last, s_nbytes, input s_ready);
    modport slave  (input s_valid, s_data, s_last, s_nbytes, output s_ready);
endinterface

// File: rtl/blake2b_mblock_loader.sv
// BLAKE2b message-block loader: packs a 64-bit word stream into 16-word blocks,
// supplies the chaining value (IV-derived or core feedback), and tracks the
// byte counter and final-block flag for the compress core.
module blake2b_mblock_loader #(
    parameter int unsigned WORD_W  = 64,
    parameter int unsigned M_WORDS = 16,
    parameter int unsigned H_WORDS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    blake2b_mblock_loader_if.slave     s,
    input  logic [H_WORDS*WORD_W-1:0]  h_init_i,
    input  logic [H_WORDS*WORD_W-1:0]  h_fb_i,
    input  logic                       h_fb_valid_i,
    output logic                       blk_valid_o,
    input  logic                       blk_ready_i,
    output logic [M_WORDS*WORD_W-1:0]  m_o,
    output logic [H_WORDS*WORD_W-1:0]  h_o,
    output logic [127:0]               t_o,
    output logic                       f_o
);
    localparam int unsigned CNT_W = $clog2(M_WORDS);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILL    = 2'd1;
    localparam logic [1:0] ST_PRESENT = 2'd2;
    localparam logic [1:0] ST_WAIT_H  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             block_full;
    logic [3:0]       add_bytes;
    logic [127:0]     add_ext;

    // s_ready is gated by rst so it reads 0 while reset is held, even though state is IDLE
    assign s.s_ready   = rst && ((state == ST_IDLE) || (state == ST_FILL));
    assign blk_valid_o = (state == ST_PRESENT);
    assign accept      = s.s_valid && s.s_ready;
    assign block_full  = (cnt == CNT_W'(M_WORDS - 1));
    assign add_ext     = {124'd0, add_bytes};

    // Bytes contributed by the accepted word: 8, or s_nbytes on the last word (out-of-range -> 8)
    always_comb begin
        add_bytes = 4'd8;
        if (s.s_last && (s.s_nbytes != 4'd0) && (s.s_nbytes <= 4'd8)) begin
            add_bytes = s.s_nbytes;
        end
    end

    // Block assembly FSM: collect words, present the block, wait for core feedback
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            m_o   <= '0;
            h_o   <= '0;
            t_o   <= '0;
            f_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        h_o <= h_init_i;
                        t_o <= add_ext;
                        m_o <= {{((M_WORDS - 1) * WORD_W){1'b0}}, s.s_data};
                        f_o <= s.s_last;
                        if (s.s_last) begin
                            cnt   <= '0;
                            state <= ST_PRESENT;
                        end else begin
                            cnt   <= CNT_W'(1);
                            state <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        m_o[int'(cnt)*WORD_W +: WORD_W] <= s.s_data;
                        t_o <= t_o + add_ext;
                        if (block_full || s.s_last) begin
                            cnt   <= '0;
                            f_o   <= s.s_last;
                            state <= ST_PRESENT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PRESENT: begin
                    if (blk_ready_i) begin
                        if (f_o) begin
                            f_o   <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_WAIT_H;
                        end
                    end
                end
                default: begin
                    if (h_fb_valid_i) begin
                        h_o   <= h_fb_i;
                        m_o   <= '0;
                        state <= ST_FILL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_blake2b_mblock_loader.sv
// Directed self-checking bench for blake2b_mblock_loader.
module tb_blake2b_mblock_loader;
    localparam int unsigned W  = 64;
    localparam int unsigned MW = 16;
    localparam int unsigned HW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [HW*W-1:0] h_init;
    logic [HW*W-1:0] h_fb;
    logic            h_fb_valid;
    logic            blk_ready;
    logic            blk_valid;
    logic [MW*W-1:0] m_o;
    logic [HW*W-1:0] h_o;
    logic [127:0]    t_o;
    logic            f_o;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    blake2b_mblock_loader_if #(.WORD_W(W)) sif ();

    blake2b_mblock_loader #(.WORD_W(W), .M_WORDS(MW), .H_WORDS(HW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s            (sif.slave),
        .h_init_i     (h_init),
        .h_fb_i       (h_fb),
        .h_fb_valid_i (h_fb_valid),
        .blk_valid_o  (blk_valid),
        .blk_ready_i  (blk_ready),
        .m_o          (m_o),
        .h_o          (h_o),
        .t_o          (t_o),
        .f_o          (f_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input int unsigned m, input int unsigned i);
        return {16'hC0DE, m[15:0], i[31:0]};
    endfunction

    function automatic logic [HW*W-1:0] mk_h(input int unsigned seed);
        logic [HW*W-1:0] h;
        for (int unsigned i = 0; i < HW; i++) h[i*W +: W] = {seed[31:0], 32'hA5A5_0000 | i};
        return h;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded)
    task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
        int unsigned n;
        sif.s_valid = 1'b1; sif.s_data = d; sif.s_last = l; sif.s_nbytes = nb;
        n = 0;
        while (sif.s_ready !== 1'b1 && n < 300) begin tick(); n++; end
        if (n >= 300) begin
            chk_cnt++;
            $display("FAIL send_word_timeout word=%h s_ready=%b required=1", d, sif.s_ready);
        end else begin
            tick();
        end
        sif.s_valid = 1'b0; sif.s_last = 1'b0; sif.s_nbytes = 4'd0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (blk_valid !== 1'b0) $display("FAIL rst_blk_valid got=%b exp=0", blk_valid); else pass_cnt++;
        chk_cnt++; if (sif.s_ready !== 1'b0) $display("FAIL rst_s_ready got=%b exp=0", sif.s_ready); else pass_cnt++;
        chk_cnt++; if (m_o !== '0) $display("FAIL rst_m_o got=%h exp=0", m_o); else pass_cnt++;
        chk_cnt++; if ({h_o, t_o, f_o} !== '0) $display("FAIL rst_h_t_f got=%h/%h/%b exp=0", h_o, t_o, f_o); else pass_cnt++;
        rst = 1'b1;
        #1;
        chk_cnt++; if (sif.s_ready !== 1'b1) $display("FAIL rel_s_ready got=%b exp=1", sif.s_ready); else pass_cnt++;
        h_init = mk_h(7);
        for (int unsigned i = 0; i < 5; i++) send_word(word_of(9, i), 1'b0, 4'd8);
        chk_cnt++; if (t_o !== 128'd40) $display("FAIL t1_t_mid got=%0d exp=40", t_o); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        chk_cnt++; if (m_o !== '0) $display("FAIL t1_m_o got=%h exp=0", m_o); else pass_cnt++;
        chk_cnt++; if ({h_o, t_o, f_o, blk_valid} !== '0) $display("FAIL t1_h_t_f_v got=%h/%h/%b/%b exp=0", h_o, t_o, f_o, blk_valid); else pass_cnt++;
        chk_cnt++; if (sif.s_ready !== 1'b0) $display("FAIL t1_s_ready got=%b exp=0", sif.s_ready); else pass_cnt++;
        tick();
        rst = 1'b1;
        #1;
        chk_cnt++; if ({sif.s_ready, blk_valid} !== 2'b10) $display("FAIL t1_idle got=%b exp=10", {sif.s_ready, blk_valid}); else pass_cnt++;
    endtask

    task automatic test_single_word();
        logic [MW*W-1:0] exp_m;
        logic [HW*W-1:0] hi;
        logic [63:0]     d;
        d = 64'h0000_0000_0063_6261;
        hi = mk_h(21); h_init = hi;
        exp_m = '0; exp_m[63:0] = d;
        send_word(d, 1'b1, 4'd3);
        h_init = mk_h(99);
        chk_cnt++; if (blk_valid !== 1'b1) $display("FAIL t2_blk_valid got=%b exp=1", blk_valid); else pass_cnt++;
        chk_cnt++; if (m_o !== exp_m) $display("FAIL t2_m_o got=%h exp=%h", m_o, exp_m); else pass_cnt++;
        chk_cnt++; if (h_o !== hi) $display("FAIL t2_h_o got=%h exp=%h", h_o, hi); else pass_cnt++;
        chk_cnt++; if (t_o !== 128'd3) $display("FAIL t2_t_o got=%0d exp=3", t_o); else pass_cnt++;
        chk_cnt++; if ({f_o, sif.s_ready} !== 2'b10) $display("FAIL t2_f_ready got=%b exp=10", {f_o, sif.s_ready}); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        chk_cnt++; if ({blk_valid, sif.s_ready} !== 2'b01) $display("FAIL t2_idle got=%b exp=01", {blk_valid, sif.s_ready}); else pass_cnt++;
    endtask

    task automatic test_stall();
        logic [MW*W-1:0] exp_m;
        logic [HW*W-1:0] hi, hf;
        hi = mk_h(31); hf = mk_h(32); h_init = hi;
        exp_m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            send_word(word_of(3, i), 1'b0, 4'd8);
            exp_m[i*W +: W] = word_of(3, i);
        end
        for (int k = 0; k < 6; k++) begin
            chk_cnt++; if ({blk_valid, f_o} !== 2'b10) $display("FAIL t3_stall%0d_vf got=%b exp=10", k, {blk_valid, f_o}); else pass_cnt++;
            chk_cnt++; if (t_o !== 128'd128) $display("FAIL t3_stall%0d_t got=%0d exp=128", k, t_o); else pass_cnt++;
            chk_cnt++; if (m_o !== exp_m) $display("FAIL t3_stall%0d_m got=%h exp=%h", k, m_o, exp_m); else pass_cnt++;
            chk_cnt++; if (h_o !== hi) $display("FAIL t3_stall%0d_h got=%h exp=%h", k, h_o, hi); else pass_cnt++;
            if (k < 5) tick();
        end
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        chk_cnt++; if ({blk_valid, sif.s_ready} !== 2'b00) $display("FAIL t3_wait got=%b exp=00", {blk_valid, sif.s_ready}); else pass_cnt++;
        repeat (3) tick();
        chk_cnt++; if (sif.s_ready !== 1'b0) $display("FAIL t3_wait_hold got=%b exp=0", sif.s_ready); else pass_cnt++;
        h_fb = hf; h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0; h_fb = mk_h(0);
        chk_cnt++; if (sif.s_ready !== 1'b1) $display("FAIL t3_fill_ready got=%b exp=1", sif.s_ready); else pass_cnt++;
        chk_cnt++; if (h_o !== hf) $display("FAIL t3_h_fb got=%h exp=%h", h_o, hf); else pass_cnt++;
        exp_m = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            send_word(word_of(3, 16 + i), (i == 3), 4'd8);
            exp_m[i*W +: W] = word_of(3, 16 + i);
        end
        chk_cnt++; if ({blk_valid, f_o} !== 2'b11) $display("FAIL t3_b2_vf got=%b exp=11", {blk_valid, f_o}); else pass_cnt++;
        chk_cnt++; if (t_o !== 128'd160) $display("FAIL t3_b2_t got=%0d exp=160", t_o); else pass_cnt++;
        chk_cnt++; if (m_o !== exp_m) $display("FAIL t3_b2_m got=%h exp=%h", m_o, exp_m); else pass_cnt++;
        chk_cnt++; if (h_o !== hf) $display("FAIL t3_b2_h got=%h exp=%h", h_o, hf); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        chk_cnt++; if ({blk_valid, sif.s_ready} !== 2'b01) $display("FAIL t3_idle got=%b exp=01", {blk_valid, sif.s_ready}); else pass_cnt++;
    endtask

    task automatic test_exact_multiple();
        logic [MW*W-1:0] exp_m;
        h_init = mk_h(41);
        for (int unsigned i = 0; i < 16; i++) send_word(word_of(4, i), 1'b0, 4'd8);
        chk_cnt++; if ({blk_valid, f_o, t_o} !== {2'b10, 128'd128}) $display("FAIL t4_b1 got=%b%b/%0d exp=10/128", blk_valid, f_o, t_o); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        h_fb = mk_h(42); h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0;
        exp_m = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            send_word(word_of(4, 16 + i), (i == 15), 4'd8);
            exp_m[i*W +: W] = word_of(4, 16 + i);
        end
        chk_cnt++; if ({blk_valid, f_o, t_o} !== {2'b11, 128'd256}) $display("FAIL t4_b2 got=%b%b/%0d exp=11/256", blk_valid, f_o, t_o); else pass_cnt++;
        chk_cnt++; if (m_o !== exp_m) $display("FAIL t4_b2_m got=%h exp=%h", m_o, exp_m); else pass_cnt++;
        chk_cnt++; if (h_o !== mk_h(42)) $display("FAIL t4_b2_h got=%h exp=%h", h_o, mk_h(42)); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        repeat (4) tick();
        chk_cnt++; if ({blk_valid, sif.s_ready} !== 2'b01) $display("FAIL t4_no_third got=%b exp=01", {blk_valid, sif.s_ready}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int unsigned     lens[3];
        logic [3:0]      nbs[3];
        int unsigned     nblk, nw, n, nbe;
        logic [MW*W-1:0] exp_m;
        logic [HW*W-1:0] exp_h;
        logic [127:0]    exp_t;
        logic            exp_f;
        lens = '{5, 17, 3};
        nbs  = '{4'd5, 4'd2, 4'd0};
        fork
            begin
                for (int unsigned m = 0; m < 3; m++) begin
                    h_init = mk_h(50 + m);
                    for (int unsigned i = 0; i < lens[m]; i++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_word(word_of(60 + m, i), (i == lens[m] - 1), (i == lens[m] - 1) ? nbs[m] : 4'd8);
                    end
                end
            end
            begin
                for (int unsigned m = 0; m < 3; m++) begin
                    nblk = (lens[m] + 15) / 16;
                    for (int unsigned b = 0; b < nblk; b++) begin
                        nw = (lens[m] - b * 16 > 16) ? 16 : lens[m] - b * 16;
                        exp_f = (b == nblk - 1);
                        nbe = (nbs[m] == 4'd0) ? 8 : int'(nbs[m]);
                        exp_t = 128'(b * 128 + (nw - 1) * 8 + (exp_f ? nbe : 8));
                        exp_h = (b == 0) ? mk_h(50 + m) : mk_h(1000 + m * 16 + b - 1);
                        exp_m = '0;
                        for (int unsigned k = 0; k < nw; k++) exp_m[k*W +: W] = word_of(60 + m, b * 16 + k);
                        n = 0;
                        while (blk_valid !== 1'b1 && n < 400) begin tick(); n++; end
                        if (n >= 400) begin
                            chk_cnt++;
                            $display("FAIL t5_blk_timeout msg=%0d blk=%0d blk_valid=%b required=1", m, b, blk_valid);
                        end else begin
                            repeat ($urandom_range(0, 3)) tick();
                            chk_cnt++; if (m_o !== exp_m) $display("FAIL t5_m msg=%0d blk=%0d got=%h exp=%h", m, b, m_o, exp_m); else pass_cnt++;
                            chk_cnt++; if (h_o !== exp_h) $display("FAIL t5_h msg=%0d blk=%0d got=%h exp=%h", m, b, h_o, exp_h); else pass_cnt++;
                            chk_cnt++; if (t_o !== exp_t) $display("FAIL t5_t msg=%0d blk=%0d got=%0d exp=%0d", m, b, t_o, exp_t); else pass_cnt++;
                            chk_cnt++; if ({blk_valid, f_o} !== {1'b1, exp_f}) $display("FAIL t5_vf msg=%0d blk=%0d got=%b exp=1%b", m, b, {blk_valid, f_o}, exp_f); else pass_cnt++;
                            blk_ready = 1'b1; tick(); blk_ready = 1'b0;
                            if (!exp_f) begin
                                repeat ($urandom_range(0, 2)) tick();
                                h_fb = mk_h(1000 + m * 16 + b); h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0;
                            end
                        end
                    end
                end
            end
        join
        tick();
        chk_cnt++; if ({blk_valid, sif.s_ready} !== 2'b01) $display("FAIL t5_end got=%b exp=01", {blk_valid, sif.s_ready}); else pass_cnt++;
    endtask

    task automatic test_hfb_ignored();
        logic [HW*W-1:0] hi;
        hi = mk_h(70); h_init = hi;
        send_word(word_of(7, 0), 1'b0, 4'd8);
        send_word(word_of(7, 1), 1'b0, 4'd8);
        h_fb = mk_h(71); h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0;
        chk_cnt++; if (h_o !== hi) $display("FAIL t6_fill_h got=%h exp=%h", h_o, hi); else pass_cnt++;
        chk_cnt++; if ({sif.s_ready, blk_valid} !== 2'b10) $display("FAIL t6_fill_state got=%b exp=10", {sif.s_ready, blk_valid}); else pass_cnt++;
        send_word(word_of(7, 2), 1'b1, 4'd0);
        chk_cnt++; if ({blk_valid, f_o, t_o} !== {2'b11, 128'd24}) $display("FAIL t6_nb0 got=%b%b/%0d exp=11/24", blk_valid, f_o, t_o); else pass_cnt++;
        h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0;
        chk_cnt++; if ({blk_valid, h_o} !== {1'b1, hi}) $display("FAIL t6_present_h got=%b/%h exp=1/%h", blk_valid, h_o, hi); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
        h_fb_valid = 1'b1; tick(); h_fb_valid = 1'b0;
        chk_cnt++; if (h_o !== hi) $display("FAIL t6_idle_h got=%h exp=%h", h_o, hi); else pass_cnt++;
        chk_cnt++; if ({sif.s_ready, blk_valid} !== 2'b10) $display("FAIL t6_idle_state got=%b exp=10", {sif.s_ready, blk_valid}); else pass_cnt++;
        h_init = mk_h(72);
        send_word(word_of(8, 0), 1'b1, 4'd12);
        chk_cnt++; if ({blk_valid, f_o, t_o} !== {2'b11, 128'd8}) $display("FAIL t6_nb12 got=%b%b/%0d exp=11/8", blk_valid, f_o, t_o); else pass_cnt++;
        chk_cnt++; if (h_o !== mk_h(72)) $display("FAIL t6_nb12_h got=%h exp=%h", h_o, mk_h(72)); else pass_cnt++;
        blk_ready = 1'b1; tick(); blk_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired passed=%0d total=%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        sif.s_valid = 1'b0; sif.s_data = '0; sif.s_last = 1'b0; sif.s_nbytes = 4'd0;
        h_init = '0; h_fb = '0; h_fb_valid = 1'b0; blk_ready = 1'b0;
        test_reset();
        test_single_word();
        test_stall();
        test_exact_multiple();
        test_back_to_back();
        test_hfb_ignored();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
